// File: rtl/fp8_mul_arbiter.sv
// Round-robin arbiter sharing one FP8 (E4M3) multiplier between two requesters.
// Trivially-zero products bypass the multiplier and answer in one cycle.
module fp8_mul_arbiter #(
  parameter int MUL_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req_valid,
  output logic [1:0] o_req_ready,
  input  logic [7:0] i_req0_x,
  input  logic [7:0] i_req0_y,
  input  logic [7:0] i_req1_x,
  input  logic [7:0] i_req1_y,
  output logic [1:0] o_resp_valid,
  input  logic [1:0] i_resp_ready,
  output logic [7:0] o_resp_data,
  output logic [7:0] o_mul_a,
  output logic [7:0] o_mul_b,
  output logic       o_mul_start,
  input  logic [7:0] i_mul_p,
  output logic       o_busy,
  output logic [7:0] o_done_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [3:0] LAT     = 4'(MUL_LAT);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_ptr;
  logic       r_owner;
  logic [3:0] r_cnt;
  logic [7:0] r_mul_a;
  logic [7:0] r_mul_b;
  logic [7:0] r_resp_data;
  logic [7:0] r_done_cnt;
  logic       r_busy;

  logic       w_idle;
  logic       w_grant;
  logic       w_accept;
  logic [7:0] w_x;
  logic [7:0] w_y;
  logic       w_bypass;
  logic       w_resp_fire;

  // Pointer only breaks ties; a lone requester always wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant  = (i_req_valid == 2'b10) | ((i_req_valid == 2'b11) & r_ptr);
  assign w_accept = w_idle & (|i_req_valid);
  assign w_x      = w_grant ? i_req1_x : i_req0_x;
  assign w_y      = w_grant ? i_req1_y : i_req0_y;

  // A NaN operand must go through the multiplier even when the other is zero.
  assign w_bypass = ((w_x[6:0] == 7'h00) | (w_y[6:0] == 7'h00)) &
                    (w_x[6:0] != 7'h7F) & (w_y[6:0] != 7'h7F);

  assign w_resp_fire = (r_state == S_RESP) & i_resp_ready[r_owner];

  assign o_req_ready  = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign o_resp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign o_mul_start  = (r_state == S_START);
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_resp_data  = r_resp_data;
  assign o_done_cnt   = r_done_cnt;
  assign o_busy       = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_bypass ? S_RESP : S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_cnt       <= 4'd0;
      r_mul_a     <= 8'd0;
      r_mul_b     <= 8'd0;
      r_resp_data <= 8'd0;
      r_done_cnt  <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mul_a <= w_x;
            r_mul_b <= w_y;
            r_owner <= w_grant;
            if (w_bypass) r_resp_data <= {w_x[7] ^ w_y[7], 7'b0};
          end
        end
        S_START: r_cnt <= LAT;
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_resp_data <= i_mul_p;
        end
        S_RESP: begin
          if (w_resp_fire) begin
            r_done_cnt <= r_done_cnt + 8'd1;
            r_ptr      <= ~r_owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Bench for fp8_mul_arbiter: directed table, corner sequences, and a random
// run against a transaction-level timeline model.
module tb_fp8_mul_arbiter;

  localparam int L = 1;

  logic       clk, rst;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0] r0x, r0y, r1x, r1y, resp_data, mul_a, mul_b, mul_p, done_cnt;
  logic       mul_start, busy;

  logic [1:0] q_req_valid, q_req_ready, q_resp_valid;
  logic [7:0] q_x, q_y, q_resp_data, q_mul_a, q_mul_b, q_mul_p, q_done;
  logic       q_mul_start, q_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Bench multiplier: E4M3 normals, subnormals flushed, truncating, saturating.
  function automatic logic [7:0] fpmul(logic [7:0] a, logic [7:0] b);
    logic s;
    int   e, prod;
    logic [2:0] m;
    s = a[7] ^ b[7];
    if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return {s, 7'h7F};
    if (a[6:3] == 0 || b[6:3] == 0) return {s, 7'h00};
    prod = int'({1'b1, a[2:0]}) * int'({1'b1, b[2:0]});
    e = int'(a[6:3]) + int'(b[6:3]) - 7;
    if (prod >= 128) begin m = 3'(prod >> 4); e = e + 1; end
    else m = 3'(prod >> 3);
    if (e <= 0) return {s, 7'h00};
    if (e > 15 || (e == 15 && m == 3'd7)) return {s, 7'h7E};
    return {s, 4'(e), m};
  endfunction

  assign mul_p = fpmul(mul_a, mul_b);

  fp8_mul_arbiter #(.MUL_LAT(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req0_x(r0x), .i_req0_y(r0y), .i_req1_x(r1x), .i_req1_y(r1y),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_start(mul_start), .i_mul_p(mul_p),
    .o_busy(busy), .o_done_cnt(done_cnt));

  fp8_mul_arbiter #(.MUL_LAT(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(q_req_valid), .o_req_ready(q_req_ready),
    .i_req0_x(q_x), .i_req0_y(q_y), .i_req1_x(8'h00), .i_req1_y(8'h00),
    .o_resp_valid(q_resp_valid), .i_resp_ready(2'b11), .o_resp_data(q_resp_data),
    .o_mul_a(q_mul_a), .o_mul_b(q_mul_b), .o_mul_start(q_mul_start), .i_mul_p(q_mul_p),
    .o_busy(q_busy), .o_done_cnt(q_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req_valid = 0; resp_ready = 0; r0x = 0; r0y = 0; r1x = 0; r1y = 0;
    q_req_valid = 0; q_x = 0; q_y = 0; q_mul_p = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_op(input bit idx, input logic [7:0] x, input logic [7:0] y,
                       input bit byp, input logic [7:0] exp_d);
    int k, start_k;
    bit seen;
    logic [7:0] d_exp;
    d_exp = done_cnt + 8'd1;
    @(posedge clk); #1;
    req_valid = idx ? 2'b10 : 2'b01;
    if (idx) begin r1x = x; r1y = y; end else begin r0x = x; r0y = y; end
    resp_ready = 2'b11;
    @(negedge clk);
    chk("accept_ready", req_ready, idx ? 2'b10 : 2'b01);
    k = 0; seen = 0; start_k = -1;
    do begin
      @(posedge clk); #1;
      req_valid = 2'b00;
      k++;
      @(negedge clk);
      if (mul_start) begin
        seen = 1; start_k = k;
        chk("mul_a", mul_a, x);
        chk("mul_b", mul_b, y);
      end
    end while (resp_valid == 2'b00 && k < 40);
    chk("latency", k, byp ? 1 : L + 2);
    chk("resp_valid", resp_valid, idx ? 2'b10 : 2'b01);
    chk("resp_data", resp_data, exp_d);
    chk("start_seen", seen, !byp);
    if (!byp) chk("start_cycle", start_k, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_inc", done_cnt, d_exp);
    chk("busy_idle", busy, 0);
  endtask

  function automatic int bgrant(logic [1:0] v, int p);
    if (v == 2'b11) return p;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [7:0] rop();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return {1'($urandom), 7'h00};
    if (r == 1) return {1'($urandom), 7'h7F};
    return 8'($urandom);
  endfunction

  task automatic rand_test(input int ncyc);
    bit m_idle;
    int m_owner, m_ptr, m_vcyc, m_scyc, g;
    logic [7:0] m_data, m_a, m_b, m_done, x, y;
    logic [1:0] e_rdy, e_rv;
    m_idle = 1; m_owner = 0; m_ptr = 0; m_vcyc = 0; m_scyc = -1;
    m_data = 0; m_a = 0; m_b = 0; m_done = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom); resp_ready = 2'($urandom);
      r0x = rop(); r0y = rop(); r1x = rop(); r1y = rop();
      @(negedge clk);
      g = bgrant(req_valid, m_ptr);
      e_rdy = (m_idle && req_valid != 0) ? (g ? 2'b10 : 2'b01) : 2'b00;
      e_rv  = (!m_idle && c >= m_vcyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_req_ready", req_ready, e_rdy);
      chk("rnd_resp_valid", resp_valid, e_rv);
      chk("rnd_mul_start", mul_start, (!m_idle && c == m_scyc));
      chk("rnd_busy", busy, !m_idle);
      chk("rnd_done", done_cnt, m_done);
      if (e_rv != 0) chk("rnd_data", resp_data, m_data);
      if (!m_idle && c == m_scyc) chk("rnd_mul_ab", {mul_a, mul_b}, {m_a, m_b});
      if (m_idle && req_valid != 0) begin
        x = g ? r1x : r0x; y = g ? r1y : r0y;
        m_owner = g; m_a = x; m_b = y; m_idle = 0;
        if ((x[6:0] == 0 || y[6:0] == 0) && x[6:0] != 7'h7F && y[6:0] != 7'h7F) begin
          m_data = {x[7] ^ y[7], 7'h00}; m_scyc = -1; m_vcyc = c + 1;
        end else begin
          m_data = fpmul(x, y); m_scyc = c + 1; m_vcyc = c + 2 + L;
        end
      end else if (!m_idle && c >= m_vcyc && resp_ready[m_owner]) begin
        m_done = m_done + 8'd1; m_ptr = 1 - m_owner; m_idle = 1;
      end
    end
    req_valid = 0;
  endtask

  typedef struct {
    bit         idx;
    logic [7:0] x, y;
    bit         byp;
    logic [7:0] exp_d;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   gq[$];
    logic [7:0] hold_d;
    int   k;

    tbl[0] = '{1'b0, 8'h48, 8'h54, 1'b0, 8'h64};
    tbl[1] = '{1'b1, 8'h00, 8'h10, 1'b1, 8'h00};
    tbl[2] = '{1'b0, 8'h80, 8'h30, 1'b1, 8'h80};
    tbl[3] = '{1'b1, 8'h00, 8'h7F, 1'b0, fpmul(8'h00, 8'h7F)};
    tbl[4] = '{1'b0, 8'h30, 8'hB8, 1'b0, fpmul(8'h30, 8'hB8)};
    tbl[5] = '{1'b1, 8'h7F, 8'h80, 1'b0, fpmul(8'h7F, 8'h80)};
    tbl[6] = '{1'b0, 8'h83, 8'h00, 1'b1, 8'h80};
    tbl[7] = '{1'b1, 8'hFF, 8'h00, 1'b0, fpmul(8'hFF, 8'h00)};

    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_mul", {mul_a, mul_b, 7'd0, mul_start}, 0);
    chk("rst_resp_data", resp_data, 0);

    for (int i = 0; i < 8; i++) do_op(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].byp, tbl[i].exp_d);

    // Contention from reset: grants must alternate starting with req0.
    do_reset();
    req_valid = 2'b11; resp_ready = 2'b11;
    r0x = 8'h30; r0y = 8'hB8; r1x = 8'h48; r1y = 8'h54;
    for (int c = 0; c < 60 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (req_ready == 2'b01) gq.push_back(0);
      else if (req_ready == 2'b10) gq.push_back(1);
      if (c == L + 2) chk("cont_first_data", resp_data, fpmul(8'h30, 8'hB8));
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("cont_grants", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) chk("cont_grant_order", gq[i], i % 2);
    repeat (8) @(posedge clk);

    // Backpressure on req1's response; req0's ready pulses must be ignored.
    #1 req_valid = 2'b10; r1x = 8'h48; r1y = 8'h54; resp_ready = 2'b00;
    hold_d = done_cnt;
    k = 0;
    do begin
      @(posedge clk); #1 req_valid = 2'b00; k++;
      @(negedge clk);
    end while (resp_valid == 2'b00 && k < 20);
    chk("bp_valid_seen", resp_valid, 2'b10);
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1 resp_ready = {1'b0, 1'(c)};
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 2'b10);
      chk("bp_resp_data", resp_data, 8'h64);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    chk("bp_done_hold", done_cnt, hold_d);
    @(posedge clk); #1 resp_ready = 2'b10; req_valid = 2'b00;
    @(posedge clk); #1 resp_ready = 2'b00;
    @(negedge clk);
    chk("bp_released", {resp_valid, 7'd0, busy}, 0);
    chk("bp_done", done_cnt, hold_d + 8'd1);

    // Asynchronous reset while the multiplier op is in WAIT.
    @(posedge clk); #1 req_valid = 2'b01; r0x = 8'h48; r0y = 8'h54; resp_ready = 2'b11;
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_mul", {mul_a, mul_b, 7'd0, mul_start}, 0);
    chk("arst_data_done", {resp_data, done_cnt}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("arst_ptr_req0", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);

    // done_cnt wrap: back-to-back bypass ops, one handshake per two cycles.
    do_reset();
    req_valid = 2'b01; r0x = 8'h00; r0y = 8'h10; resp_ready = 2'b11;
    repeat (510) @(posedge clk);
    @(negedge clk);
    chk("wrap_255", done_cnt, 8'd255);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wrap_0", done_cnt, 8'd0);
    #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // MUL_LAT=4: only the cycle-5 product may be captured.
    do_reset();
    @(posedge clk); #1 q_req_valid = 2'b01; q_x = 8'h48; q_y = 8'h54; q_mul_p = 8'hA5;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      q_req_valid = 2'b00;
      q_mul_p = 8'($urandom);
      if (q_mul_p == 8'h5A) q_mul_p = 8'h5B;
      if (c == 5) q_mul_p = 8'h5A;
      @(negedge clk);
      if (c == 1) chk("lat4_start", q_mul_start, 1);
      if (c == 5) chk("lat4_not_yet", q_resp_valid, 2'b00);
      if (c == 6) begin
        chk("lat4_valid", q_resp_valid, 2'b01);
        chk("lat4_data", q_resp_data, 8'h5A);
      end
    end
    repeat (3) @(posedge clk);

    rand_test(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp8_mul_arbiter.md
# fp8_mul_arbiter

Shares one FP8 (E4M3: sign, 4-bit exponent with bias 7, 3-bit mantissa) multiplier between two requesters. It arbitrates round-robin, sequences the multiplier over a parameterized latency, and returns each product to its owner over a valid/ready handshake. A zero-operand bypass answers trivially-zero products without occupying the multiplier. Sits between the front-end operand sources and the existing combinational/pipelined FP8 multiplier core.

## Interface
- MUL_LAT, 1, cycles from the `mul_start` cycle until `mul_p` is valid; legal range 1–15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i set: requester i presents operands.
- req_ready  out  2  bit i set: requester i is accepted this cycle (combinational).
- req0_x, req0_y  in  8 each  requester 0 operands.
- req1_x, req1_y  in  8 each  requester 1 operands.
- resp_valid  out  2  one-hot or zero; bit i set: `resp_data` belongs to requester i.
- resp_ready  in  2  requester i consumes the response.
- resp_data  out  8  product register.
- mul_a, mul_b  out  8 each  registered operands to the multiplier.
- mul_start  out  1  one-cycle pulse that launches the multiplier.
- mul_p  in  8  multiplier product.
- busy  out  1  high in any state other than IDLE.
- done_cnt  out  8  count of completed response handshakes; wraps 255→0.

## Operation
- States: IDLE, START, WAIT, RESP.
- Reset values: state IDLE; all outputs 0; priority pointer = 0; internal counter 0. Reset mid-operation discards the in-flight op with no response.
- IDLE, grant:
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's requester is granted.
  - `req_ready` is high only for the granted bit. It is never asserted outside IDLE.
  - Dropping `req_valid` before acceptance is legal, and nothing is captured.
- Accept (valid & ready): latch `mul_a`/`mul_b` and set owner = i.
  - Bypass: taken if (x[6:0]==0 or y[6:0]==0) and neither x[6:0] nor y[6:0] equals 7'h7F (NaN). Load `resp_data` = {x[7]^y[7], 7'b0} and go to RESP. `mul_start` stays 0.
  - Otherwise go to START.
- START: `mul_start`=1 for exactly this cycle. Load counter = MUL_LAT and go to WAIT.
- WAIT: counter decrements each cycle. In the cycle where counter==1, capture `resp_data` ← `mul_p` and go to RESP.
- RESP:
  - `resp_valid[owner]`=1 and `resp_data` is stable until `resp_ready[owner]`.
  - `resp_ready` of the non-owner is ignored.
  - On handshake: `done_cnt`+1 (mod 256), pointer ← other requester, go to IDLE.
- The pointer changes only on response completion. Back-to-back requests from both requesters therefore strictly alternate.
- `mul_a`/`mul_b` hold their values until the next accept.
- `resp_data` holds its value after the handshake and is only meaningful while `resp_valid` is set.

## Timing
- Accept in cycle 0.
  - Normal path: `mul_start` in cycle 1; `mul_p` sampled at end of cycle 1+MUL_LAT; `resp_valid` from cycle 2+MUL_LAT.
  - Bypass: `resp_valid` from cycle 1.
- Response handshake in cycle n gives IDLE in cycle n+1; the earliest next accept is cycle n+1.
- Peak throughput with an immediately-ready consumer:
  - normal: one op per MUL_LAT+3 cycles;
  - bypass: one op per 2 cycles.
- `req_ready` depends combinationally on `req_valid` and state only, not on `resp_ready`.
- `busy` is registered and tracks the state: 0 in IDLE, 1 otherwise.

## Test plan
- Single op, MUL_LAT=1, bench multiplier model: req0 {0x48, 0x54} → `mul_start` in cycle 1 with `mul_a`=0x48, `mul_b`=0x54; model returns 0x64; `resp_valid`=2'b01 with `resp_data`=0x64 in cycle 3; `done_cnt`=1 after the handshake.
- Contention, both valid from reset: first grant is req0 (0x30×0xB8), second is req1. With both held valid for 4 ops, grants alternate 0,1,0,1.
- Bypass:
  - req1 {0x00, 0x10} → no `mul_start`; `resp_valid`=2'b10 and `resp_data`=0x00 in cycle 1.
  - {0x80, 0x30} → 0x80.
  - {0x00, 0x7F} → normal path, `mul_start` pulses.
- Backpressure: hold `resp_ready`=0 for 10 cycles in RESP → `resp_valid` and `resp_data` stable, `req_ready`=0 throughout. Pulsing the non-owner's `resp_ready` has no effect.
- MUL_LAT=4: `mul_p` is driven valid only in cycle 5, with garbage before → captured value equals the cycle-5 value; `resp_valid` in cycle 6.
- Reset mid-WAIT: assert `rst` asynchronously → all outputs 0 immediately, no `resp_valid`. Pointer returns to 0: with both requesters valid after reset, req0 wins. `done_cnt` wraps 255→0 after 256 handshakes.
